// File: rtl/mem_arb_pkg.sv
// Shared types and default sizes for the single-port memory arbiter.
// The response owner enum tags which requester the next cycle's read data belongs to.
package mem_arb_pkg;

  localparam int ADDR_W_DEF       = 16;
  localparam int DATA_W_DEF       = 32;
  localparam int MAX_DATA_RUN_DEF = 4;

  typedef enum logic [1:0] {
    RSP_NONE = 2'd0,
    RSP_IF   = 2'd1,
    RSP_LS   = 2'd2
  } rsp_owner_t;

endpackage

// File: rtl/mem_arb_starve_cnt.sv
// Saturating run counter of back-to-back load/store grants taken while fetch waits.
// Raises force_if once the run reaches MAX_DATA_RUN so fetch gets the next slot.
module mem_arb_starve_cnt
  import mem_arb_pkg::*;
#(
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic if_req,
  input  logic ls_gnt,
  input  logic if_gnt,
  output logic force_if
);

  localparam logic [3:0] MAX_CNT = 4'(MAX_DATA_RUN);

  logic [3:0] run_cnt_q;
  logic [3:0] run_cnt_d;

  // A fetch grant or an idle fetch port ends the run; otherwise count ls wins.
  always_comb begin
    run_cnt_d = run_cnt_q;
    if (if_gnt || !if_req) begin
      run_cnt_d = 4'd0;
    end else if (ls_gnt && (run_cnt_q != MAX_CNT)) begin
      run_cnt_d = run_cnt_q + 4'd1;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      run_cnt_q <= 4'd0;
    end else begin
      run_cnt_q <= run_cnt_d;
    end
  end

  assign force_if = if_req & (run_cnt_q == MAX_CNT);

endmodule

// File: rtl/mem_arbiter.sv
// Arbitrates one synchronous single-port memory between fetch and load/store,
// with load/store priority, bounded fetch starvation and 1-cycle read routing.
module mem_arbiter
  import mem_arb_pkg::*;
#(
  parameter int ADDR_W       = ADDR_W_DEF,
  parameter int DATA_W       = DATA_W_DEF,
  parameter int MAX_DATA_RUN = MAX_DATA_RUN_DEF
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              if_req_i,
  input  logic [ADDR_W-1:0] if_addr_i,
  output logic              if_gnt_o,
  output logic              if_rvalid_o,
  output logic [DATA_W-1:0] if_rdata_o,
  input  logic              ls_req_i,
  input  logic              ls_we_i,
  input  logic [ADDR_W-1:0] ls_addr_i,
  input  logic [DATA_W-1:0] ls_wdata_i,
  output logic              ls_gnt_o,
  output logic              ls_rvalid_o,
  output logic [DATA_W-1:0] ls_rdata_o,
  output logic [ADDR_W-1:0] mem_a_o,
  output logic              mem_w_o,
  output logic [DATA_W-1:0] mem_d_o,
  input  logic [DATA_W-1:0] mem_q_i,
  output logic              if_stall_o
);

  logic       force_if;
  rsp_owner_t rsp_owner_q;
  rsp_owner_t rsp_owner_d;

  mem_arb_starve_cnt #(
    .MAX_DATA_RUN(MAX_DATA_RUN)
  ) u_starve_cnt (
    .clk     (clk),
    .rst     (rst),
    .if_req  (if_req_i),
    .ls_gnt  (ls_gnt_o),
    .if_gnt  (if_gnt_o),
    .force_if(force_if)
  );

  assign ls_gnt_o   = ls_req_i & ~force_if & ~rst;
  assign if_gnt_o   = if_req_i & ~ls_gnt_o & ~rst;
  assign if_stall_o = if_req_i & ~if_gnt_o;

  // Memory port mux: the idle memory sees address 0 with no write.
  always_comb begin
    mem_a_o = '0;
    mem_w_o = 1'b0;
    mem_d_o = '0;
    if (ls_gnt_o) begin
      mem_a_o = ls_addr_i;
      mem_w_o = ls_we_i;
      mem_d_o = ls_wdata_i;
    end else if (if_gnt_o) begin
      mem_a_o = if_addr_i;
    end
  end

  always_comb begin
    rsp_owner_d = RSP_NONE;
    if (ls_gnt_o && !ls_we_i) begin
      rsp_owner_d = RSP_LS;
    end else if (if_gnt_o) begin
      rsp_owner_d = RSP_IF;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      rsp_owner_q <= RSP_NONE;
    end else begin
      rsp_owner_q <= rsp_owner_d;
    end
  end

  // Gated by rst so a read granted just before reset never reports valid.
  assign if_rvalid_o = (rsp_owner_q == RSP_IF) & ~rst;
  assign ls_rvalid_o = (rsp_owner_q == RSP_LS) & ~rst;
  assign if_rdata_o  = mem_q_i;
  assign ls_rdata_o  = mem_q_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Directed plus randomized bench for mem_arbiter against a rule-level reference model
// and a behavioural 64K x 32 synchronous memory.
module tb_mem_arbiter;

  localparam int AW  = 16;
  localparam int DW  = 32;
  localparam int MAX = 4;

  logic          clk = 1'b0;
  logic          rst;
  logic          if_req_i;
  logic [AW-1:0] if_addr_i;
  logic          if_gnt_o, if_rvalid_o;
  logic [DW-1:0] if_rdata_o;
  logic          ls_req_i, ls_we_i;
  logic [AW-1:0] ls_addr_i;
  logic [DW-1:0] ls_wdata_i;
  logic          ls_gnt_o, ls_rvalid_o;
  logic [DW-1:0] ls_rdata_o;
  logic [AW-1:0] mem_a_o;
  logic          mem_w_o;
  logic [DW-1:0] mem_d_o;
  logic [DW-1:0] mem_q_i = '0;
  logic          if_stall_o;

  mem_arbiter #(.ADDR_W(AW), .DATA_W(DW), .MAX_DATA_RUN(MAX)) dut (
    .clk(clk), .rst(rst),
    .if_req_i(if_req_i), .if_addr_i(if_addr_i), .if_gnt_o(if_gnt_o),
    .if_rvalid_o(if_rvalid_o), .if_rdata_o(if_rdata_o),
    .ls_req_i(ls_req_i), .ls_we_i(ls_we_i), .ls_addr_i(ls_addr_i),
    .ls_wdata_i(ls_wdata_i), .ls_gnt_o(ls_gnt_o),
    .ls_rvalid_o(ls_rvalid_o), .ls_rdata_o(ls_rdata_o),
    .mem_a_o(mem_a_o), .mem_w_o(mem_w_o), .mem_d_o(mem_d_o),
    .mem_q_i(mem_q_i), .if_stall_o(if_stall_o)
  );

  always #5 clk = ~clk;

  logic [DW-1:0] macro_mem [0:65535];
  logic [DW-1:0] shadow    [0:65535];

  always @(posedge clk) begin
    if (mem_w_o) macro_mem[mem_a_o] <= mem_d_o;
    mem_q_i <= macro_mem[mem_a_o];
  end

  int vectors    = 0;
  int miscompares = 0;

  // Reference model state: starvation run length and the outstanding read.
  int            run_m  = 0;
  int            pend_m = 0;   // 0 none, 1 fetch, 2 load
  logic [DW-1:0] pend_data = '0;

  logic          e_if, e_ls;
  logic          o_if, o_ls, o_irv, o_lrv;
  logic [DW-1:0] o_lrd;

  task automatic chk(input string tag, input logic [DW-1:0] obs, input logic [DW-1:0] exp);
    vectors++;
    assert (obs === exp) else begin
      miscompares++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic apply(input logic r, input logic ifr, input logic [AW-1:0] ifa,
                       input logic lsr, input logic we, input logic [AW-1:0] lsa,
                       input logic [DW-1:0] wd);
    logic frc, e_irv, e_lrv;
    rst = r; if_req_i = ifr; if_addr_i = ifa;
    ls_req_i = lsr; ls_we_i = we; ls_addr_i = lsa; ls_wdata_i = wd;
    @(negedge clk);
    frc   = ifr && (run_m == MAX);
    e_ls  = lsr && !frc && !r;
    e_if  = ifr && !e_ls && !r;
    e_irv = (pend_m == 1) && !r;
    e_lrv = (pend_m == 2) && !r;
    o_if = if_gnt_o; o_ls = ls_gnt_o; o_irv = if_rvalid_o; o_lrv = ls_rvalid_o;
    o_lrd = ls_rdata_o;
    chk("if_gnt", 32'(if_gnt_o), 32'(e_if));
    chk("ls_gnt", 32'(ls_gnt_o), 32'(e_ls));
    chk("if_stall", 32'(if_stall_o), 32'(ifr && !e_if));
    chk("if_rvalid", 32'(if_rvalid_o), 32'(e_irv));
    chk("ls_rvalid", 32'(ls_rvalid_o), 32'(e_lrv));
    chk("rvalid_excl", 32'(if_rvalid_o & ls_rvalid_o), 32'd0);
    if (e_irv) chk("if_rdata", if_rdata_o, pend_data);
    if (e_lrv) chk("ls_rdata", ls_rdata_o, pend_data);
    if (e_ls) begin
      chk("mem_a_ls", 32'(mem_a_o), 32'(lsa));
      chk("mem_w_ls", 32'(mem_w_o), 32'(we));
      chk("mem_d_ls", mem_d_o, wd);
    end else if (e_if) begin
      chk("mem_a_if", 32'(mem_a_o), 32'(ifa));
      chk("mem_w_if", 32'(mem_w_o), 32'd0);
    end else begin
      chk("mem_a_idle", 32'(mem_a_o), 32'd0);
      chk("mem_w_idle", 32'(mem_w_o), 32'd0);
      chk("mem_d_idle", mem_d_o, 32'd0);
    end
    @(posedge clk);
    if (e_ls && we) shadow[lsa] = wd;
    if (r)                    pend_m = 0;
    else if (e_if)          begin pend_m = 1; pend_data = shadow[ifa]; end
    else if (e_ls && !we)   begin pend_m = 2; pend_data = shadow[lsa]; end
    else                      pend_m = 0;
    if (r || e_if || !ifr)    run_m = 0;
    else if (e_ls && run_m < MAX) run_m++;
    #1;
  endtask

  task automatic idle();
    apply(1'b0, 1'b0, '0, 1'b0, 1'b0, '0, '0);
  endtask

  logic          c_if, c_ls, c_we, c_rst;
  logic [AW-1:0] c_ifa, c_lsa;
  logic [DW-1:0] c_wd;

  initial begin
    for (int i = 0; i < 65536; i++) begin
      macro_mem[i] = 32'(i) * 32'h9E37_79B9 ^ 32'h5A5A_0F0F;
      shadow[i]    = macro_mem[i];
    end
    rst = 1'b1; if_req_i = 1'b0; if_addr_i = '0; ls_req_i = 1'b0;
    ls_we_i = 1'b0; ls_addr_i = '0; ls_wdata_i = '0;
    @(posedge clk); #1;

    // Reset: no grants, stall follows fetch request.
    apply(1'b1, 1'b1, 16'h0010, 1'b1, 1'b0, 16'h0020, '0);
    apply(1'b1, 1'b0, '0, 1'b0, 1'b0, '0, '0);
    idle();

    // Fetch only, addresses 0..3.
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 16'(i), 1'b0, 1'b0, '0, '0);
    idle(); idle();

    // Store then load of the same word.
    apply(1'b0, 1'b0, '0, 1'b1, 1'b1, 16'h1234, 32'hDEAD_BEEF);
    apply(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h1234, '0);
    idle();
    chk("raw_load_valid", 32'(o_lrv), 32'd1);
    chk("raw_load_data", o_lrd, 32'hDEAD_BEEF);

    // Contention for 10 cycles: LS x4 then IF, repeated.
    for (int i = 0; i < 10; i++) begin
      apply(1'b0, 1'b1, 16'(16'h0100 + i), 1'b1, 1'b0, 16'(16'h0200 + i), '0);
      chk("contention_if", 32'(o_if), 32'((i % 5) == 4));
    end
    idle(); idle();

    // Fetch withdraws after three ls grants; run restarts from zero.
    for (int i = 0; i < 3; i++) apply(1'b0, 1'b1, 16'h0300, 1'b1, 1'b0, 16'(16'h0400 + i), '0);
    apply(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h0410, '0);
    apply(1'b0, 1'b1, 16'h0300, 1'b1, 1'b0, 16'h0411, '0);
    chk("withdraw_ls", 32'(o_ls), 32'd1);
    for (int i = 0; i < 4; i++) apply(1'b0, 1'b1, 16'h0300, 1'b1, 1'b0, 16'(16'h0420 + i), '0);
    idle();

    // Reset in the cycle after a granted fetch drops the response.
    apply(1'b0, 1'b1, 16'h0055, 1'b0, 1'b0, '0, '0);
    apply(1'b1, 1'b1, 16'h0056, 1'b1, 1'b0, 16'h0057, '0);
    chk("rst_mid_rvalid", 32'(o_irv), 32'd0);
    chk("rst_mid_gnt", 32'({o_if, o_ls}), 32'd0);
    idle(); idle();

    // Alternating fetch then load responses.
    apply(1'b0, 1'b1, 16'h0005, 1'b0, 1'b0, '0, '0);
    apply(1'b0, 1'b0, '0, 1'b1, 1'b0, 16'h0006, '0);
    chk("alt_if_rvalid", 32'(o_irv), 32'd1);
    idle();
    chk("alt_ls_rvalid", 32'(o_lrv), 32'd1);
    idle();

    // Randomized traffic; requests held until granted unless withdrawn.
    c_if = 1'b0; c_ls = 1'b0; c_we = 1'b0; c_ifa = '0; c_lsa = '0; c_wd = '0;
    for (int n = 0; n < 500; n++) begin
      c_rst = ($urandom_range(0, 63) == 0);
      apply(c_rst, c_if, c_ifa, c_ls, c_we, c_lsa, c_wd);
      if (e_if || !c_if || $urandom_range(0, 7) == 0) begin
        c_if  = ($urandom_range(0, 3) != 0);
        c_ifa = 16'($urandom_range(0, 15));
      end
      if (e_ls || !c_ls || $urandom_range(0, 7) == 0) begin
        c_ls  = ($urandom_range(0, 3) != 0);
        c_we  = $urandom_range(0, 1) == 1;
        c_lsa = 16'($urandom_range(0, 15));
        c_wd  = $urandom;
      end
    end
    idle();

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule

// File: doc/mem_arbiter.md
# mem_arbiter

Single-port memory arbiter sharing one 32-bit × 64K synchronous memory between the instruction-fetch port and the load/store port of the core. It sits between the fetch/execute stages and the memory macro. It grants at most one access per cycle, with load/store priority and a bounded-starvation guarantee for fetch. It routes the one-cycle-latency read data back to the requester that issued the read.

## Interface
- ADDR_W, 16, memory word-address width
- DATA_W, 32, data width
- MAX_DATA_RUN, 4, maximum consecutive load/store grants while fetch is waiting; legal range 1..15
- clk  in  1  system clock
- rst  in  1  synchronous, active-high reset
- if_req_i  in  1  fetch read request
- if_addr_i  in  ADDR_W  fetch address
- if_gnt_o  out  1  fetch request accepted this cycle
- if_rvalid_o  out  1  fetch read data valid
- if_rdata_o  out  DATA_W  fetch read data
- ls_req_i  in  1  load/store request
- ls_we_i  in  1  1 = store, 0 = load
- ls_addr_i  in  ADDR_W  load/store address
- ls_wdata_i  in  DATA_W  store data
- ls_gnt_o  out  1  load/store request accepted this cycle
- ls_rvalid_o  out  1  load data valid
- ls_rdata_o  out  DATA_W  load data
- mem_a_o  out  ADDR_W  memory address
- mem_w_o  out  1  memory write enable
- mem_d_o  out  DATA_W  memory write data
- mem_q_i  in  DATA_W  memory read data, valid one cycle after the address
- if_stall_o  out  1  if_req_i & ~if_gnt_o; drives the fetch stall

## Operation
- Request handshake:
  - A requester raises req with address and data, and holds them stable until gnt is seen high in the same cycle.
  - The request is consumed on that edge.
  - Dropping req before grant is legal: it withdraws the request and produces no memory access.
- Grant rule (combinational, evaluated each cycle):
  - force_if = if_req_i & (run_cnt == MAX_DATA_RUN).
  - ls_gnt_o = ls_req_i & ~force_if & ~rst.
  - if_gnt_o = if_req_i & ~ls_gnt_o & ~rst.
  - Both grants are never high together.
- Starvation counter run_cnt (4 bits):
  - Increments on an ls grant while if_req_i is high; saturates at MAX_DATA_RUN.
  - Clears to 0 on any if grant, or in any cycle with if_req_i low.
- Memory drive:
  - When ls is granted: mem_a_o = ls_addr_i, mem_w_o = ls_we_i, mem_d_o = ls_wdata_i.
  - When if is granted: mem_a_o = if_addr_i, mem_w_o = 0.
  - When nothing is granted: mem_a_o = 0, mem_w_o = 0, mem_d_o = 0.
- Response tracker rsp_owner ∈ {RSP_NONE, RSP_IF, RSP_LS}, registered:
  - RSP_IF on a granted fetch; RSP_LS on a granted load; RSP_NONE on a granted store or no grant.
- Response outputs:
  - if_rvalid_o = (rsp_owner == RSP_IF).
  - ls_rvalid_o = (rsp_owner == RSP_LS).
  - if_rdata_o and ls_rdata_o both carry mem_q_i; they are meaningful only while the matching rvalid is high.
- Stores produce no response.
- Read-after-write to the same address in consecutive cycles returns the new data, as provided by the memory.

## Timing
- Grant latency is 0 cycles: gnt is in the same cycle as req.
- Read data latency is 1 cycle: rvalid is in the cycle after the grant.
- Throughput is one access per cycle; back-to-back grants to the same or alternating ports are permitted.
- Reset values: run_cnt = 0, rsp_owner = RSP_NONE.
  - While rst is high: both gnt = 0, both rvalid = 0, mem_w_o = 0, mem_a_o = 0, if_stall_o = if_req_i.
- Reset mid-operation: a read granted in the cycle before rst produces no rvalid; the response is dropped and the requester must reissue.
- Simultaneous requests with run_cnt < MAX_DATA_RUN: ls wins, if stalls.
  - With run_cnt == MAX_DATA_RUN: if wins, ls waits one cycle, and run_cnt returns to 0.
- A response and a new grant occur in the same cycle independently; rsp_owner updates every edge.

## Structure
- Package mem_arb_pkg holds:
  - the rsp_owner_t enum {RSP_NONE, RSP_IF, RSP_LS};
  - the ADDR_W and DATA_W defaults;
  - the MAX_DATA_RUN default.
- One sub-module, mem_arb_starve_cnt: the saturating run counter.
  - Inputs: clk, rst, if_req, ls_gnt, if_gnt.
  - Output: force_if.
- Grant logic, memory muxing and the response tracker stay in mem_arbiter.

## Test plan
- Fetch only: if_req_i = 1 with addresses 0x0000..0x0003 over four cycles.
  - Required: if_gnt_o = 1 every cycle, and if_rvalid_o = 1 in cycles 2..5 with matching preloaded words.
- Load/store only:
  - Store 0xDEADBEEF to 0x1234 (ls_rvalid_o stays 0).
  - Next cycle, load 0x1234. Required: ls_rvalid_o = 1 one cycle later with ls_rdata_o = 0xDEADBEEF.
- Contention, MAX_DATA_RUN = 4: if_req_i and ls_req_i both held high for 10 cycles.
  - Required grant pattern: LS LS LS LS IF LS LS LS LS IF.
  - if_stall_o is high exactly on the LS cycles.
- Fetch withdraws: fetch requests during 3 ls grants, then drops req; next cycle ls_req_i = 1 with if_req_i = 1.
  - Required: run_cnt reset to 0, so the ls grant is given and the forced-if slot is not taken early.
- Reset mid-read: fetch read granted at cycle N, rst high at cycle N+1.
  - Required: if_rvalid_o = 0 at N+1, and all grants are 0 during reset.
- Alternating responses: fetch read in cycle N, load in cycle N+1.
  - Required: if_rvalid_o only at N+1 and ls_rvalid_o only at N+2, each with its own word; never both rvalids high together.
